// File: rtl/seg_scan_driver.sv
// Four-digit common-anode seven-segment scanner for the chess-clock countdown.
// Latches a per-frame digit snapshot, decodes BCD, and blinks while the time reads 00.00.
module seg_scan_driver #(
    parameter int unsigned SCAN_DIV     = 124999,
    parameter int unsigned BLINK_FRAMES = 125
) (
    input  logic       segclk,
    input  logic       resetn,
    input  logic       enable,
    input  logic       blank_lead,
    input  logic [3:0] cnt_msec1,
    input  logic [3:0] cnt_msec10,
    input  logic [3:0] cnt_sec1,
    input  logic [3:0] cnt_sec10,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       expired
);

    localparam int unsigned SCAN_W  = (SCAN_DIV > 0) ? $clog2(SCAN_DIV + 1) : 1;
    localparam int unsigned BLINK_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
    logic [1:0]         digit_idx_q, digit_idx_d;
    logic [3:0][3:0]    shadow_q, shadow_d;
    logic               expired_q, expired_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_phase_q, blink_phase_d;
    logic [3:0]         an_q, an_d;
    logic [6:0]         seg_q, seg_d;
    logic               dp_q, dp_d;

    logic               tick;
    logic               frame_end;
    logic               dark;
    logic [3:0]         cur_digit;

    function automatic logic [6:0] bcd_to_seg(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'h40;
            4'd1:    s = 7'h79;
            4'd2:    s = 7'h24;
            4'd3:    s = 7'h30;
            4'd4:    s = 7'h19;
            4'd5:    s = 7'h12;
            4'd6:    s = 7'h02;
            4'd7:    s = 7'h78;
            4'd8:    s = 7'h00;
            4'd9:    s = 7'h10;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    always_comb begin
        tick      = (scan_cnt_q == SCAN_W'(SCAN_DIV));
        frame_end = tick && (digit_idx_q == 2'd3);

        scan_cnt_d  = tick ? '0 : scan_cnt_q + SCAN_W'(1);
        digit_idx_d = tick ? digit_idx_q + 2'd1 : digit_idx_q;

        shadow_d  = shadow_q;
        expired_d = expired_q;
        if (frame_end) begin
            shadow_d  = {cnt_sec10, cnt_sec1, cnt_msec10, cnt_msec1};
            expired_d = (cnt_sec10 == 4'd0) && (cnt_sec1 == 4'd0) &&
                        (cnt_msec10 == 4'd0) && (cnt_msec1 == 4'd0);
        end

        // Blink state follows the registered expiry, so it restarts from phase 0 on each new expiry.
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (!expired_q) begin
            blink_cnt_d   = '0;
            blink_phase_d = 1'b0;
        end else if (frame_end) begin
            if (blink_cnt_q == BLINK_W'(BLINK_FRAMES - 1)) begin
                blink_cnt_d   = '0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BLINK_W'(1);
            end
        end

        cur_digit = shadow_q[digit_idx_q];
        dark = !enable || (expired_q && blink_phase_q) ||
               (blank_lead && (digit_idx_q == 2'd3) && (shadow_q[3] == 4'd0));

        if (dark) begin
            an_d  = '1;
            seg_d = '1;
            dp_d  = 1'b1;
        end else begin
            an_d  = ~(4'b0001 << digit_idx_q);
            seg_d = bcd_to_seg(cur_digit);
            dp_d  = (digit_idx_q != 2'd2);
        end
    end

    always_ff @(posedge segclk or negedge resetn) begin
        if (!resetn) begin
            scan_cnt_q    <= '0;
            digit_idx_q   <= '0;
            shadow_q      <= '1;
            expired_q     <= 1'b0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            an_q          <= '1;
            seg_q         <= '1;
            dp_q          <= 1'b1;
        end else begin
            scan_cnt_q    <= scan_cnt_d;
            digit_idx_q   <= digit_idx_d;
            shadow_q      <= shadow_d;
            expired_q     <= expired_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            an_q          <= an_d;
            seg_q         <= seg_d;
            dp_q          <= dp_d;
        end
    end

    assign an      = an_q;
    assign seg     = seg_q;
    assign dp      = dp_q;
    assign expired = expired_q;

endmodule
